// File: rtl/pipelined_cla_adder_pkg.sv
// Shared constants and elaboration helpers for the pipelined carry-lookahead adder.
package cla_pkg;
  localparam int CLA_WIDTH = 32;
  localparam int CLA_BLOCK = 8;

  function automatic bit cla_params_ok(int width, int block);
    return (block >= 1) && (width >= block) && (width % block == 0);
  endfunction

  function automatic int cla_stages(int width, int block);
    return (block >= 1) ? width / block : 1;
  endfunction
endpackage

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result streaming bus: valid/ready on both the operand and result sides.
interface pipelined_cla_adder_if import cla_pkg::*; #(parameter int WIDTH = CLA_WIDTH) ();
  logic             validIn;
  logic             readyIn;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic             carryIn;
  logic             subIn;
  logic             validOut;
  logic             readyOut;
  logic [WIDTH-1:0] dataOut;
  logic             carryOut;
  logic             overflowOut;

  modport master (
    output validIn, dataA, dataB, carryIn, subIn, readyOut,
    input  readyIn, validOut, dataOut, carryOut, overflowOut
  );

  modport slave (
    input  validIn, dataA, dataB, carryIn, subIn, readyOut,
    output readyIn, validOut, dataOut, carryOut, overflowOut
  );
endinterface

// File: rtl/pipelined_cla_adder_group.sv
// Combinational BLOCK-bit lookahead group; every carry is a flat sum of
// generate/propagate products rather than a ripple chain.
module cla_group #(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);
  logic [BLOCK-1:0] g;
  logic [BLOCK-1:0] p;
  logic [BLOCK:0]   c;
  logic             term;
  logic             prop;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c    = '0;
    term = 1'b0;
    prop = 1'b1;
    c[0] = cin;
    for (int i = 0; i < BLOCK; i++) begin
      term = 1'b0;
      prop = 1'b1;
      for (int j = i; j >= 0; j--) begin
        term = term | (prop & g[j]);
        prop = prop & p[j];
      end
      c[i+1] = term | (prop & cin);
    end
  end

  assign sum  = p ^ c[BLOCK-1:0];
  assign cout = c[BLOCK];
  assign cmsb = c[BLOCK-1];
endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined add/subtract: one lookahead group per stage, registered group carry,
// operand skew and result deskew registers, elastic valid/ready with full backpressure.
module pipelined_cla_adder import cla_pkg::*; #(
  parameter int WIDTH = CLA_WIDTH,
  parameter int BLOCK = CLA_BLOCK
) (
  input logic                  clk,
  input logic                  rstN,
  pipelined_cla_adder_if.slave bus
);
  localparam int STAGES = cla_stages(WIDTH, BLOCK);

  if (!cla_params_ok(WIDTH, BLOCK)) begin : g_param_check
    $error("pipelined_cla_adder: WIDTH must be a non-zero multiple of BLOCK");
  end

  logic [STAGES-1:0]            valid_q, valid_d;
  logic [STAGES-1:0]            carry_q, carry_d;
  logic [STAGES-1:0]            cmsb_q, cmsb_d;
  logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
  logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
  logic [STAGES-1:0][WIDTH-1:0] res_q, res_d;
  logic [STAGES-1:0]            adv;

  logic [BLOCK-1:0] grp_a   [STAGES];
  logic [BLOCK-1:0] grp_b   [STAGES];
  logic [BLOCK-1:0] grp_sum [STAGES];
  logic             grp_cin [STAGES];
  logic             grp_cout[STAGES];
  logic             grp_cmsb[STAGES];

  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic             unused_skew;

  // Subtraction folds into the adder as A + ~B + ~borrow.
  assign b_eff = bus.subIn ? ~bus.dataB : bus.dataB;
  assign c0    = bus.subIn ^ bus.carryIn;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign grp_a[k]   = bus.dataA[BLOCK-1:0];
      assign grp_b[k]   = b_eff[BLOCK-1:0];
      assign grp_cin[k] = c0;
    end else begin : g_body
      assign grp_a[k]   = a_q[k-1][k*BLOCK +: BLOCK];
      assign grp_b[k]   = b_q[k-1][k*BLOCK +: BLOCK];
      assign grp_cin[k] = carry_q[k-1];
    end

    cla_group #(.BLOCK(BLOCK)) u_group (
      .a    (grp_a[k]),
      .b    (grp_b[k]),
      .cin  (grp_cin[k]),
      .sum  (grp_sum[k]),
      .cout (grp_cout[k]),
      .cmsb (grp_cmsb[k])
    );
  end

  always_comb begin
    valid_d = valid_q;
    carry_d = carry_q;
    cmsb_d  = cmsb_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;

    // A stage may move when it is empty or the stage after it moves.
    adv[STAGES-1] = !valid_q[STAGES-1] || bus.readyOut;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv[k] = !valid_q[k] || adv[k+1];
    end

    if (adv[0]) begin
      valid_d[0]            = bus.validIn;
      a_d[0]                = bus.dataA;
      b_d[0]                = b_eff;
      res_d[0]              = '0;
      res_d[0][BLOCK-1:0]   = grp_sum[0];
      carry_d[0]            = grp_cout[0];
      cmsb_d[0]             = grp_cmsb[0];
    end

    for (int k = 1; k < STAGES; k++) begin
      if (adv[k]) begin
        valid_d[k]                   = valid_q[k-1];
        a_d[k]                       = a_q[k-1];
        b_d[k]                       = b_q[k-1];
        res_d[k]                     = res_q[k-1];
        res_d[k][k*BLOCK +: BLOCK]   = grp_sum[k];
        carry_d[k]                   = grp_cout[k];
        cmsb_d[k]                    = grp_cmsb[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      valid_q <= '0;
      carry_q <= '0;
      cmsb_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      cmsb_q  <= cmsb_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  assign bus.readyIn     = adv[0];
  assign bus.validOut    = valid_q[STAGES-1];
  assign bus.dataOut     = res_q[STAGES-1];
  assign bus.carryOut    = carry_q[STAGES-1];
  assign bus.overflowOut = carry_q[STAGES-1] ^ cmsb_q[STAGES-1];

  // Operand slices already consumed and non-final MSB carries are dead bits.
  assign unused_skew = ^{a_q, b_q, cmsb_q};
endmodule

// File: doc/pipelined_cla_adder.md
# pipelined_cla_adder

Parametrised, pipelined carry-lookahead add/subtract unit; the multi-cycle successor to our single-cycle 8-bit CLA adder. Splits a WIDTH-bit operation into BLOCK-bit lookahead groups, one group per pipeline stage. The group carry is registered between stages. A valid/ready handshake on both sides lets the unit sit between a streaming operand source and a result consumer, with full backpressure.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of BLOCK (elaboration error otherwise)
- BLOCK, 8, bits per lookahead group (one pipeline stage per group); STAGES = WIDTH/BLOCK
- clk  input  1  clock, all state on rising edge
- rstN  input  1  reset; one clock; synchronous, active-low
- validIn  input  1  operand beat valid
- readyIn  output  1  unit can accept operand beat this cycle
- dataA  input  WIDTH  operand A
- dataB  input  WIDTH  operand B
- carryIn  input  1  carry-in (add) / borrow-in (sub)
- subIn  input  1  0: A+B+carryIn; 1: A-B-carryIn
- validOut  output  1  result beat valid
- readyOut  input  1  consumer accepts result this cycle
- dataOut  output  WIDTH  sum/difference
- carryOut  output  1  carry out of MSB (sub: 1 = no borrow)
- overflowOut  output  1  signed overflow (carry into MSB XOR carry out of MSB)

## Operation
- Effective operands: B' = subIn ? ~dataB : dataB; c0 = subIn ? ~carryIn : carryIn. The core always computes A + B' + c0, modulo 2^WIDTH.
- Stage k (0..STAGES-1) computes result bits [k*BLOCK +: BLOCK] with a BLOCK-bit lookahead group fed by the registered carry from stage k-1 (stage 0: c0).
- Upper operand slices travel forward in skew registers. Completed lower result slices travel forward in deskew registers. All WIDTH bits present at the last stage together.
- Stage k also registers the carry into its top bit. The last stage uses it for overflowOut.
- Per-stage valid bit. Stage k advances when it is empty or stage k+1 advances. The last stage advances when !validOut or readyOut.
- Beat accepted when validIn && readyIn. readyIn = stage 0 empty or advancing. This is combinational from readyOut through the stage chain; no skid buffer.
- Beats never reorder, duplicate or drop. Data registers of empty stages may hold stale values; only valid qualifies outputs.

## Timing
- Reset (rstN low at a clock edge): all stage valids cleared.
  - validOut=0 and readyIn=1 from the following cycle.
  - dataOut, carryOut, overflowOut = 0.
  - In-flight beats are discarded.
  - A beat presented during the reset cycle is not accepted.
- Latency: a beat accepted at edge n appears on validOut after edge n+STAGES-1, i.e. STAGES cycles from presentation with no stall. STAGES=1 gives a registered single-cycle adder.
- Throughput: one beat per cycle with readyOut held high.
- Stall: while validOut && !readyOut, outputs hold stable. Bubbles ahead of the stall collapse.
- readyIn falls only when all STAGES valids are set and the last stage is stalled. At most STAGES beats are in flight.
- Simultaneous accept and output in one cycle is legal when full.
- validIn without readyIn: the source must hold the operands; the unit does not sample them.

## Structure
- Package cla_pkg: parameter legality check function (WIDTH % BLOCK == 0, BLOCK >= 1), stage-count helper function, default WIDTH/BLOCK constants.
- Sub-module cla_group: combinational BLOCK-bit lookahead group.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, and the carry into its MSB.
  - Instantiated STAGES times by generate.
- Top level holds the per-stage valid, carry and skew/deskew registers plus the handshake logic.

## Test plan
- WIDTH=32, BLOCK=8, readyOut=1: A=1, B=2, carryIn=1, subIn=0 -> dataOut=4, carryOut=0, overflowOut=0, exactly 4 cycles after acceptance.
- Full carry ripple: A=0xFFFFFFFF, B=1, cin=0 -> dataOut=0, carryOut=1. Also A=0x7FFFFFFF, B=1 -> 0x80000000, overflowOut=1, carryOut=0.
- Subtract: 5-6 -> 0xFFFFFFFF, carryOut=0, overflowOut=0. 0x80000000-1 -> 0x7FFFFFFF, overflowOut=1, carryOut=1. 2-5 with carryIn=1 -> 0xFFFFFFFC.
- Backpressure: stream 10 random beats with validIn=1; readyOut low for 6 cycles mid-stream.
  - readyIn drops once 4 beats are held.
  - Outputs stay stable while stalled.
  - All 10 results arrive in order and match the reference model; none lost or duplicated.
- Reset mid-stream: 3 beats in flight, rstN low one cycle -> validOut=0 next cycle, no stale result afterwards. The first post-reset beat 5+6 -> 11 after 4 cycles.
- Parameter sweep WIDTH=8/BLOCK=8 (latency 1), WIDTH=16/BLOCK=4 (latency 4), WIDTH=12/BLOCK=3: exhaustive/random add and sub vs model; WIDTH=12/BLOCK=5 must fail elaboration.
